bp_be_fe_queue_ckpt: RTL and testbench

- Checkpointing FIFO between the front end and the back end.
- Holds fetched instruction packets and presents them to the BE scheduler on a valid/yumi interface.
- Keeps every issued-but-uncommitted entry so the BE can commit entries one at a time (deq), replay from the last commit point (roll), or flush everything (clr).
- The BE drives yumi/clr/deq/roll; the FE drives the enqueue side.

---
 rtl/bp_be_fe_queue_ckpt.sv | 94 +++++++++
 tb/tb_bp_be_fe_queue_ckpt.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/bp_be_fe_queue_ckpt.sv
// Checkpointing FE->BE instruction queue.
// Entries stay resident after issue until the BE commits them (deq), so the
// BE can rewind the speculative read pointer to the commit point (roll) or
// discard everything (clr). Pointers carry one extra wrap bit so that full
// and empty can be told apart without a separate counter.
module bp_be_fe_queue_ckpt #(
    parameter int width_p = 128,
    parameter int els_p   = 8
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [width_p-1:0] fe_queue_i,
    input  logic               fe_queue_v_i,
    output logic               fe_queue_ready_o,
    output logic [width_p-1:0] fe_queue_o,
    output logic               fe_queue_v_o,
    input  logic               fe_queue_yumi_i,
    input  logic               fe_queue_deq_i,
    input  logic               fe_queue_roll_i,
    input  logic               fe_queue_clr_i
);

    localparam int idx_w_lp     = $clog2(els_p);
    localparam int ptr_width_lp = idx_w_lp + 1;

    logic [ptr_width_lp-1:0] wptr_r, rptr_r, cptr_r;
    logic [ptr_width_lp-1:0] wptr_n, rptr_n, cptr_n;
    logic [width_p-1:0]      mem_r [els_p];
    logic                    full;
    logic                    enq;

    // Full: same slot index, opposite lap. Only registered state is used so
    // the FE never sees ready depend on same-cycle BE commits.
    assign full = (wptr_r[idx_w_lp-1:0] == cptr_r[idx_w_lp-1:0])
               && (wptr_r[idx_w_lp] != cptr_r[idx_w_lp]);

    assign fe_queue_ready_o = reset_n_i & ~full;
    assign fe_queue_v_o     = reset_n_i & (rptr_r != wptr_r);
    assign fe_queue_o       = mem_r[rptr_r[idx_w_lp-1:0]];
    assign enq              = fe_queue_v_i & fe_queue_ready_o;

    // Next-pointer logic: clr dominates; otherwise commit first, then roll
    // to the updated commit point, else issue. Enqueue advances wptr always.
    always_comb begin
        wptr_n = wptr_r + {{(ptr_width_lp-1){1'b0}}, enq};
        cptr_n = cptr_r;
        rptr_n = rptr_r;
        if (fe_queue_clr_i) begin
            cptr_n = wptr_n;
            rptr_n = wptr_n;
        end else begin
            cptr_n = cptr_r + {{(ptr_width_lp-1){1'b0}}, fe_queue_deq_i};
            if (fe_queue_roll_i)
                rptr_n = cptr_n;
            else
                rptr_n = rptr_r + {{(ptr_width_lp-1){1'b0}}, fe_queue_yumi_i};
        end
    end

    // Pointer registers with asynchronous clear.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_r <= '0;
            rptr_r <= '0;
            cptr_r <= '0;
        end else begin
            wptr_r <= wptr_n;
            rptr_r <= rptr_n;
            cptr_r <= cptr_n;
        end
    end

    // Packet storage; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk_i) begin
        if (enq)
            mem_r[wptr_r[idx_w_lp-1:0]] <= fe_queue_i;
    end

`ifndef SYNTHESIS
    // Protocol checks on BE/FE control inputs while out of reset.
    always @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (!$isunknown({fe_queue_v_i, fe_queue_yumi_i, fe_queue_deq_i,
                                 fe_queue_roll_i, fe_queue_clr_i}))
                else $error("fe_queue: X on control input");
            assert (!(fe_queue_yumi_i && !fe_queue_v_o))
                else $error("fe_queue: yumi with no valid output");
            assert (!(fe_queue_deq_i && (cptr_r == rptr_r)))
                else $error("fe_queue: deq with no issued entry");
        end
    end
`endif

endmodule

// File: tb/tb_bp_be_fe_queue_ckpt.sv
// Self-checking bench for bp_be_fe_queue_ckpt: directed scenarios plus a
// randomized run checked against a queue-based reference model.
module tb_bp_be_fe_queue_ckpt;

    localparam int W  = 32;
    localparam int EL = 8;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] fe_queue_i;
    logic         fe_queue_v_i;
    logic         fe_queue_ready_o;
    logic [W-1:0] fe_queue_o;
    logic         fe_queue_v_o;
    logic         fe_queue_yumi_i;
    logic         fe_queue_deq_i;
    logic         fe_queue_roll_i;
    logic         fe_queue_clr_i;

    int total = 0;
    int bad   = 0;

    // Reference model: mq holds every uncommitted entry, oldest first;
    // iss counts how many of them have been issued to the BE.
    logic [W-1:0] mq[$];
    int           iss = 0;

    bp_be_fe_queue_ckpt #(.width_p(W), .els_p(EL)) dut (
        .clk_i            (clk),
        .reset_n_i        (reset_n),
        .fe_queue_i       (fe_queue_i),
        .fe_queue_v_i     (fe_queue_v_i),
        .fe_queue_ready_o (fe_queue_ready_o),
        .fe_queue_o       (fe_queue_o),
        .fe_queue_v_o     (fe_queue_v_o),
        .fe_queue_yumi_i  (fe_queue_yumi_i),
        .fe_queue_deq_i   (fe_queue_deq_i),
        .fe_queue_roll_i  (fe_queue_roll_i),
        .fe_queue_clr_i   (fe_queue_clr_i)
    );

    always #5 clk = ~clk;

    function automatic logic m_v();
        return iss < mq.size();
    endfunction

    function automatic logic m_ready();
        return mq.size() < EL;
    endfunction

    function automatic logic [W-1:0] m_out();
        return mq[iss];
    endfunction

    task automatic idle_inputs();
        fe_queue_i = '0; fe_queue_v_i = 0; fe_queue_yumi_i = 0;
        fe_queue_deq_i = 0; fe_queue_roll_i = 0; fe_queue_clr_i = 0;
    endtask

    // One clock: drive at negedge, update model at posedge, idle at +1.
    task automatic step(input logic enq, input logic [W-1:0] d,
                        input logic yu, input logic dq, input logic rl, input logic cl);
        logic acc;
        @(negedge clk);
        fe_queue_v_i = enq; fe_queue_i = d; fe_queue_yumi_i = yu;
        fe_queue_deq_i = dq; fe_queue_roll_i = rl; fe_queue_clr_i = cl;
        @(posedge clk);
        if (reset_n) begin
            acc = enq && m_ready();
            if (cl) begin
                mq.delete(); iss = 0;
            end else begin
                if (dq) begin void'(mq.pop_front()); iss--; end
                if (rl) iss = 0;
                else if (yu) iss++;
                if (acc) mq.push_back(d);
            end
        end
        #1;
        idle_inputs();
    endtask

    task automatic test_reset();
        reset_n = 0; idle_inputs();
        #12;
        total++; if (fe_queue_v_o !== 1'b0) begin bad++; $display("FAIL rst_v got=%b exp=0", fe_queue_v_o); end
        total++; if (fe_queue_ready_o !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", fe_queue_ready_o); end
        @(negedge clk); reset_n = 1; #1;
        total++; if (fe_queue_ready_o !== 1'b1) begin bad++; $display("FAIL post_rst_ready got=%b exp=1", fe_queue_ready_o); end
        total++; if (fe_queue_v_o !== 1'b0) begin bad++; $display("FAIL post_rst_v got=%b exp=0", fe_queue_v_o); end
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 8; i++) begin
            step(1, W'(i), 0, 0, 0, 0);
            total++;
            if (fe_queue_ready_o !== (i < 8)) begin bad++; $display("FAIL fill_ready i=%0d got=%b exp=%b", i, fe_queue_ready_o, (i < 8)); end
        end
        for (int i = 1; i <= 8; i++) begin
            total++;
            if (fe_queue_v_o !== 1'b1 || fe_queue_o !== W'(i)) begin
                bad++; $display("FAIL drain_data i=%0d got=%h v=%b exp=%h", i, fe_queue_o, fe_queue_v_o, i);
            end
            step(0, '0, 1, (i > 1), 0, 0);
            if (i == 2) begin
                total++;
                if (fe_queue_ready_o !== 1'b1) begin bad++; $display("FAIL drain_ready got=%b exp=1", fe_queue_ready_o); end
            end
        end
        total++; if (fe_queue_v_o !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b exp=0", fe_queue_v_o); end
        step(0, '0, 0, 1, 0, 0);
    endtask

    task automatic test_roll_replay();
        step(1, 32'hA, 0, 0, 0, 0);
        step(1, 32'hB, 0, 0, 0, 0);
        step(1, 32'hC, 0, 0, 0, 0);
        step(0, '0, 1, 0, 0, 0);
        step(0, '0, 1, 0, 0, 0);
        step(0, '0, 0, 1, 0, 0);
        step(0, '0, 0, 0, 1, 0);
        total++; if (fe_queue_v_o !== 1'b1 || fe_queue_o !== 32'hB) begin bad++; $display("FAIL roll_data got=%h exp=b", fe_queue_o); end
        step(0, '0, 1, 0, 0, 0);
        total++; if (fe_queue_o !== 32'hC) begin bad++; $display("FAIL roll_c got=%h exp=c", fe_queue_o); end
        step(0, '0, 1, 0, 0, 0);
        total++; if (fe_queue_v_o !== 1'b0) begin bad++; $display("FAIL roll_empty got=%b exp=0", fe_queue_v_o); end
        // Occupancy 2: six more fit, ready drops after the sixth.
        for (int i = 0; i < 6; i++) step(1, W'(i), 0, 0, 0, 0);
        total++; if (fe_queue_ready_o !== 1'b0) begin bad++; $display("FAIL roll_occ got=%b exp=0", fe_queue_ready_o); end
        step(0, '0, 0, 0, 0, 1);
    endtask

    task automatic test_clr_enq();
        step(1, 32'h1, 0, 0, 0, 0);
        step(1, 32'h2, 0, 0, 0, 0);
        step(1, 32'h3, 0, 0, 0, 0);
        step(0, '0, 1, 0, 0, 0);
        step(1, 32'h55, 0, 0, 0, 1);
        total++; if (fe_queue_v_o !== 1'b0) begin bad++; $display("FAIL clr_v got=%b exp=0", fe_queue_v_o); end
        total++; if (fe_queue_ready_o !== 1'b1) begin bad++; $display("FAIL clr_ready got=%b exp=1", fe_queue_ready_o); end
        step(1, 32'h66, 0, 0, 0, 0);
        total++; if (fe_queue_v_o !== 1'b1 || fe_queue_o !== 32'h66) begin bad++; $display("FAIL clr_next got=%h exp=66", fe_queue_o); end
        step(0, '0, 0, 0, 0, 1);
    endtask

    task automatic test_deq_roll();
        step(1, 32'hA, 0, 0, 0, 0);
        step(1, 32'hB, 0, 0, 0, 0);
        step(1, 32'hC, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, '0, 1, 0, 0, 0);
        step(0, '0, 0, 1, 1, 0);
        total++; if (fe_queue_v_o !== 1'b1 || fe_queue_o !== 32'hB) begin bad++; $display("FAIL dqroll_data got=%h exp=b", fe_queue_o); end
        step(0, '0, 1, 0, 0, 0);
        step(0, '0, 1, 0, 0, 0);
        step(0, '0, 0, 0, 1, 0);
        total++; if (fe_queue_o !== 32'hB) begin bad++; $display("FAIL dqroll_cptr got=%h exp=b", fe_queue_o); end
        step(0, '0, 0, 0, 0, 1);
    endtask

    task automatic test_full_deq();
        logic [W-1:0] d;
        for (int i = 0; i < 8; i++) step(1, W'(32'h10 + i), 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, '0, 1, 0, 0, 0);
        total++; if (fe_queue_ready_o !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", fe_queue_ready_o); end
        step(1, 32'h99, 0, 1, 0, 0);
        total++; if (fe_queue_ready_o !== 1'b1) begin bad++; $display("FAIL full_after_deq got=%b exp=1", fe_queue_ready_o); end
        step(1, 32'h99, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(0, '0, 0, 1, 0, 0);
        total++; if (fe_queue_v_o !== 1'b1 || fe_queue_o !== 32'h99) begin bad++; $display("FAIL full_99 got=%h v=%b exp=99", fe_queue_o, fe_queue_v_o); end
        step(0, '0, 0, 0, 0, 1);
        // Three full laps of the storage.
        for (int i = 0; i < 3 * EL; i++) begin
            d = $urandom;
            step(1, d, 0, 0, 0, 0);
            total++; if (fe_queue_v_o !== 1'b1 || fe_queue_o !== d) begin bad++; $display("FAIL wrap i=%0d got=%h exp=%h", i, fe_queue_o, d); end
            step(0, '0, 1, 0, 0, 0);
            step(0, '0, 0, 1, 0, 0);
        end
    endtask

    task automatic test_async_reset();
        step(1, 32'h7, 0, 0, 0, 0);
        step(1, 32'h8, 0, 0, 0, 0);
        @(posedge clk); #3;
        reset_n = 0; #1;
        total++; if (fe_queue_v_o !== 1'b0 || fe_queue_ready_o !== 1'b0) begin bad++; $display("FAIL async_rst v=%b ready=%b exp=0,0", fe_queue_v_o, fe_queue_ready_o); end
        mq.delete(); iss = 0;
        @(negedge clk); reset_n = 1;
        step(0, '0, 0, 0, 0, 0);
        total++; if (fe_queue_v_o !== 1'b0 || fe_queue_ready_o !== 1'b1) begin bad++; $display("FAIL async_post v=%b ready=%b exp=0,1", fe_queue_v_o, fe_queue_ready_o); end
    endtask

    task automatic test_random();
        logic e, y, dq, r, c;
        for (int n = 0; n < 2000; n++) begin
            e  = ($urandom % 3) != 0;
            c  = ($urandom % 40) == 0;
            dq = (iss > 0) && (($urandom % 3) == 0);
            r  = ($urandom % 15) == 0;
            y  = m_v() && (($urandom % 2) == 0);
            step(e, $urandom, y, dq, r, c);
            total++;
            if (fe_queue_v_o !== m_v() || fe_queue_ready_o !== m_ready() ||
                (m_v() && fe_queue_o !== m_out())) begin
                bad++;
                $display("FAIL rand n=%0d v=%b/%b ready=%b/%b data=%h/%h", n,
                         fe_queue_v_o, m_v(), fe_queue_ready_o, m_ready(),
                         fe_queue_o, m_v() ? m_out() : '0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_roll_replay();
        test_clr_enq();
        test_deq_roll();
        test_full_deq();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
